axis_trace_mon: RTL and testbench



---
 rtl/axis_trace_pkg.sv | 29 ++
 rtl/axis_trace_ram.sv | 25 ++
 rtl/axis_trace_mon.sv | 201 ++++++++++++++++++++
 tb/tb_axis_trace_mon.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_trace_pkg.sv
// Shared definitions for the AXI-Stream trace monitor: capture states,
// trigger mode codes and the byte-enable population count helper.
package axis_trace_pkg;

  typedef enum logic [1:0] {
    CAP_IDLE  = 2'd0,
    CAP_ARMED = 2'd1,
    CAP_POST  = 2'd2,
    CAP_DONE  = 2'd3
  } cap_state_e;

  localparam logic [1:0] TRIG_IMMEDIATE = 2'd0;
  localparam logic [1:0] TRIG_TUSER     = 2'd1;
  localparam logic [1:0] TRIG_FSM       = 2'd2;
  localparam logic [1:0] TRIG_TLAST     = 2'd3;

  // Widest supported tkeep is 32 bits (256-bit tdata); narrower keeps are zero-extended.
  localparam int unsigned KEEP_MAX = 32;

  function automatic logic [5:0] popcount(input logic [KEEP_MAX-1:0] keep);
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < KEEP_MAX; i++) begin
      n = n + {5'd0, keep[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/axis_trace_ram.sv
// Simple dual-port capture RAM: one write port, one registered read port.
// Contents are deliberately not reset so a capture survives a monitor reset.
module axis_trace_ram #(
  parameter int DEPTH = 512,
  parameter int WIDTH = 78,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             wrEn_i,
  input  logic [AW-1:0]    wrAddr_i,
  input  logic [WIDTH-1:0] wrData_i,
  input  logic [AW-1:0]    rdAddr_i,
  output logic [WIDTH-1:0] rdData_o
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (wrEn_i) begin
      mem[wrAddr_i] <= wrData_i;
    end
    rdData_o <= mem[rdAddr_i];
  end

endmodule

// File: rtl/axis_trace_mon.sv
// AXI-Stream trace monitor: ring-buffer capture around a trigger beat plus
// free-running saturating frame/byte/error statistics.
module axis_trace_mon
  import axis_trace_pkg::*;
#(
  parameter int C_DATA_WIDTH = 64,
  parameter int C_DEPTH      = 512,
  parameter int C_FSM_WIDTH  = 4,
  localparam int KW = C_DATA_WIDTH / 8,
  localparam int AW = $clog2(C_DEPTH),
  localparam int WW = C_DATA_WIDTH + KW + 2 + C_FSM_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [C_DATA_WIDTH-1:0] mon_tdata,
  input  logic [KW-1:0]           mon_tkeep,
  input  logic                    mon_tvalid,
  input  logic                    mon_tready,
  input  logic                    mon_tlast,
  input  logic                    mon_tuser,
  input  logic [C_FSM_WIDTH-1:0]  mon_fsm,
  input  logic                    arm,
  input  logic                    clear,
  input  logic [1:0]              trig_mode,
  input  logic [C_FSM_WIDTH-1:0]  trig_fsm,
  input  logic [AW-1:0]           post_cnt,
  input  logic [AW-1:0]           rd_addr,
  output logic [WW-1:0]           rd_data,
  output logic [1:0]              cap_state,
  output logic [AW-1:0]           trig_pos,
  output logic [31:0]             stat_frames,
  output logic [31:0]             stat_bytes,
  output logic [31:0]             stat_errs
);

  localparam logic [AW:0]   FILL_FULL = (AW+1)'(C_DEPTH);
  localparam logic [AW:0]   FILL_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [AW-1:0] LAST_IDX  = AW'(C_DEPTH - 1);

  cap_state_e state_q, state_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW:0]   fill_q, fill_d;
  logic [AW-1:0] remain_q, remain_d;
  logic [AW-1:0] trigPos_q, trigPos_d;
  logic          readEn_q;
  logic [31:0]   statFrames_q, statFrames_d;
  logic [31:0]   statBytes_q, statBytes_d;
  logic [31:0]   statErrs_q, statErrs_d;

  logic          beat;
  logic          trigHit;
  logic          wrEn;
  logic [WW-1:0] wrData;
  logic [AW-1:0] oldest;
  logic [AW-1:0] rdIdx;
  logic [AW-1:0] capLimit;
  logic [WW-1:0] ramData;
  logic [32:0]   bytesSum;
  logic          frameInc;
  logic          errInc;

  assign beat     = mon_tvalid & mon_tready;
  assign wrData   = {mon_fsm, mon_tuser, mon_tlast, mon_tkeep, mon_tdata};
  assign capLimit = LAST_IDX - post_cnt;

  always_comb begin
    trigHit = 1'b0;
    case (trig_mode)
      TRIG_IMMEDIATE: trigHit = 1'b1;
      TRIG_TUSER:     trigHit = mon_tuser;
      TRIG_FSM:       trigHit = (mon_fsm == trig_fsm);
      TRIG_TLAST:     trigHit = mon_tlast;
      default:        trigHit = 1'b0;
    endcase
  end

  // Capture sequencing. The trigger index is fixed at the trigger beat: once the
  // post-trigger beats wrap the ring, the trigger lands post_cnt words before the end.
  always_comb begin
    state_d   = state_q;
    wptr_d    = wptr_q;
    fill_d    = fill_q;
    remain_d  = remain_q;
    trigPos_d = trigPos_q;
    wrEn      = 1'b0;
    case (state_q)
      CAP_IDLE, CAP_DONE: begin
        if (arm) begin
          state_d = CAP_ARMED;
          wptr_d  = '0;
          fill_d  = '0;
        end
      end
      CAP_ARMED: begin
        if (beat) begin
          wrEn   = 1'b1;
          wptr_d = wptr_q + PTR_ONE;
          fill_d = (fill_q == FILL_FULL) ? fill_q : fill_q + FILL_ONE;
          if (trigHit) begin
            trigPos_d = (fill_q > {1'b0, capLimit}) ? capLimit : fill_q[AW-1:0];
            remain_d  = post_cnt;
            state_d   = (post_cnt == '0) ? CAP_DONE : CAP_POST;
          end
        end
      end
      CAP_POST: begin
        if (beat) begin
          wrEn     = 1'b1;
          wptr_d   = wptr_q + PTR_ONE;
          fill_d   = (fill_q == FILL_FULL) ? fill_q : fill_q + FILL_ONE;
          remain_d = remain_q - PTR_ONE;
          if (remain_q == PTR_ONE) begin
            state_d = CAP_DONE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= CAP_IDLE;
      wptr_q    <= '0;
      fill_q    <= '0;
      remain_q  <= '0;
      trigPos_q <= '0;
      readEn_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      wptr_q    <= wptr_d;
      fill_q    <= fill_d;
      remain_q  <= remain_d;
      trigPos_q <= trigPos_d;
      readEn_q  <= 1'b1;
    end
  end

  // Readout is relative to the oldest word, which is the write pointer once the ring has wrapped.
  assign oldest = (fill_q == FILL_FULL) ? wptr_q : '0;
  assign rdIdx  = oldest + rd_addr;

  axis_trace_ram #(
    .DEPTH(C_DEPTH),
    .WIDTH(WW)
  ) uRam (
    .clk_i   (clk),
    .wrEn_i  (wrEn),
    .wrAddr_i(wptr_q),
    .wrData_i(wrData),
    .rdAddr_i(rdIdx),
    .rdData_o(ramData)
  );

  // The RAM has no reset, so its output is masked until the first edge after reset.
  assign rd_data = readEn_q ? ramData : '0;

  assign frameInc = beat & mon_tlast;
  assign errInc   = frameInc & mon_tuser;
  assign bytesSum = {1'b0, statBytes_q} + {27'd0, popcount(32'(mon_tkeep))};

  always_comb begin
    statFrames_d = statFrames_q;
    statBytes_d  = statBytes_q;
    statErrs_d   = statErrs_q;
    if (clear) begin
      statFrames_d = '0;
      statBytes_d  = '0;
      statErrs_d   = '0;
    end else begin
      if (frameInc && (statFrames_q != '1)) begin
        statFrames_d = statFrames_q + 32'd1;
      end
      if (errInc && (statErrs_q != '1)) begin
        statErrs_d = statErrs_q + 32'd1;
      end
      if (beat) begin
        statBytes_d = bytesSum[32] ? '1 : bytesSum[31:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      statFrames_q <= '0;
      statBytes_q  <= '0;
      statErrs_q   <= '0;
    end else begin
      statFrames_q <= statFrames_d;
      statBytes_q  <= statBytes_d;
      statErrs_q   <= statErrs_d;
    end
  end

  assign cap_state   = state_q;
  assign trig_pos    = trigPos_q;
  assign stat_frames = statFrames_q;
  assign stat_bytes  = statBytes_q;
  assign stat_errs   = statErrs_q;

endmodule

// File: tb/tb_axis_trace_mon.sv
// Randomized scoreboard bench for axis_trace_mon against a queue-based
// reference model of the capture window and the statistics counters.
module tb_axis_trace_mon;

  localparam int DW    = 64;
  localparam int DEPTH = 16;
  localparam int FW    = 4;
  localparam int KW    = DW / 8;
  localparam int AW    = 4;
  localparam int WW    = DW + KW + 2 + FW;
  localparam longint MAXU = 64'h0000_0000_FFFF_FFFF;

  logic          clk;
  logic          rst;
  logic [DW-1:0] mon_tdata;
  logic [KW-1:0] mon_tkeep;
  logic          mon_tvalid;
  logic          mon_tready;
  logic          mon_tlast;
  logic          mon_tuser;
  logic [FW-1:0] mon_fsm;
  logic          arm;
  logic          clear;
  logic [1:0]    trig_mode;
  logic [FW-1:0] trig_fsm;
  logic [AW-1:0] post_cnt;
  logic [AW-1:0] rd_addr;
  logic [WW-1:0] rd_data;
  logic [1:0]    cap_state;
  logic [AW-1:0] trig_pos;
  logic [31:0]   stat_frames;
  logic [31:0]   stat_bytes;
  logic [31:0]   stat_errs;

  axis_trace_mon #(
    .C_DATA_WIDTH(DW),
    .C_DEPTH     (DEPTH),
    .C_FSM_WIDTH (FW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mon_tdata  (mon_tdata),
    .mon_tkeep  (mon_tkeep),
    .mon_tvalid (mon_tvalid),
    .mon_tready (mon_tready),
    .mon_tlast  (mon_tlast),
    .mon_tuser  (mon_tuser),
    .mon_fsm    (mon_fsm),
    .arm        (arm),
    .clear      (clear),
    .trig_mode  (trig_mode),
    .trig_fsm   (trig_fsm),
    .post_cnt   (post_cnt),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .cap_state  (cap_state),
    .trig_pos   (trig_pos),
    .stat_frames(stat_frames),
    .stat_bytes (stat_bytes),
    .stat_errs  (stat_errs)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  // Reference model: every word stored since the last arm, in arrival order.
  int            mState = 0;
  logic [WW-1:0] capWords[$];
  int            trigAbs = 0;
  int            postLeft = 0;
  longint        mFrames = 0;
  longint        mBytes = 0;
  longint        mErrs = 0;

  logic [WW-1:0] rdExpQ[$];
  int            rdTagQ[$];
  bit            rdReq = 1'b0;

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  function automatic int windowStart();
    int n = capWords.size();
    return (n > DEPTH) ? n - DEPTH : 0;
  endfunction

  task automatic modelReset();
    mState = 0;
    capWords.delete();
    trigAbs = 0;
    mFrames = 0;
    mBytes = 0;
    mErrs = 0;
  endtask

  task automatic modelStep();
    bit beat = mon_tvalid && mon_tready;
    bit hit;
    logic [WW-1:0] word = {mon_fsm, mon_tuser, mon_tlast, mon_tkeep, mon_tdata};
    case (trig_mode)
      2'd0: hit = 1'b1;
      2'd1: hit = mon_tuser;
      2'd2: hit = (mon_fsm == trig_fsm);
      default: hit = mon_tlast;
    endcase
    if (clear) begin
      mFrames = 0;
      mBytes = 0;
      mErrs = 0;
    end else if (beat) begin
      if (mon_tlast && mFrames < MAXU) mFrames++;
      if (mon_tlast && mon_tuser && mErrs < MAXU) mErrs++;
      mBytes = mBytes + $countones(mon_tkeep);
      if (mBytes > MAXU) mBytes = MAXU;
    end
    if (mState == 0 || mState == 3) begin
      if (arm) begin
        mState = 1;
        capWords.delete();
      end
    end else if (beat) begin
      capWords.push_back(word);
      if (mState == 1) begin
        if (hit) begin
          trigAbs = capWords.size() - 1;
          postLeft = int'(post_cnt);
          mState = (postLeft == 0) ? 3 : 2;
        end
      end else begin
        postLeft--;
        if (postLeft == 0) mState = 3;
      end
    end
  endtask

  task automatic checkStatus();
    checkOutput("capState", 128'(cap_state), 128'(mState));
    checkOutput("statFrames", 128'(stat_frames), 128'(mFrames));
    checkOutput("statBytes", 128'(stat_bytes), 128'(mBytes));
    checkOutput("statErrs", 128'(stat_errs), 128'(mErrs));
    if (mState == 3) begin
      checkOutput("trigPos", 128'(trig_pos), 128'(trigAbs - windowStart()));
    end
  endtask

  // Called just after a rising edge; drives one cycle and checks the result.
  task automatic applyStimulus(input bit v, input bit r, input bit l, input bit u,
                               input logic [FW-1:0] f, input logic [KW-1:0] k);
    mon_tvalid = v;
    mon_tready = r;
    mon_tlast  = l;
    mon_tuser  = u;
    mon_fsm    = f;
    mon_tkeep  = k;
    mon_tdata  = {$urandom, $urandom};
    modelStep();
    @(posedge clk);
    #1;
    arm   = 1'b0;
    clear = 1'b0;
    checkStatus();
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic armCapture(input logic [1:0] mode, input logic [AW-1:0] post, input logic [FW-1:0] tf);
    trig_mode = mode;
    post_cnt  = post;
    trig_fsm  = tf;
    arm       = 1'b1;
    idle();
  endtask

  task automatic readWord(input int a);
    mon_tvalid = 1'b0;
    mon_tready = 1'b0;
    rd_addr    = AW'(a);
    rdExpQ.push_back(capWords[windowStart() + a]);
    rdTagQ.push_back(a);
    rdReq = 1'b1;
    @(posedge clk);
    #1;
    rdReq = 1'b0;
  endtask

  task automatic readAll();
    int cnt = (capWords.size() > DEPTH) ? DEPTH : capWords.size();
    for (int a = 0; a < cnt; a++) readWord(a);
    idle();
  endtask

  // Scoreboard monitor: a read requested before an edge is presented on the next falling edge.
  initial begin
    logic [WW-1:0] exp;
    int tag;
    forever begin
      @(posedge clk);
      if (rdReq) begin
        @(negedge clk);
        if (rdExpQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL rdData unexpected actual=%0h required=none", rd_data);
        end else begin
          exp = rdExpQ.pop_front();
          tag = rdTagQ.pop_front();
          checkOutput($sformatf("rdData[%0d]", tag), 128'(rd_data), 128'(exp));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    mon_tdata = '0; mon_tkeep = '0; mon_tvalid = 1'b0; mon_tready = 1'b0;
    mon_tlast = 1'b0; mon_tuser = 1'b0; mon_fsm = '0;
    arm = 1'b0; clear = 1'b0; trig_mode = 2'd0; trig_fsm = '0;
    post_cnt = '0; rd_addr = '0;
    modelReset();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("resetState", 128'(cap_state), 128'(0));
    checkOutput("resetTrigPos", 128'(trig_pos), 128'(0));
    checkOutput("resetRdData", 128'(rd_data), 128'(0));
    checkOutput("resetFrames", 128'(stat_frames), 128'(0));
    checkOutput("resetBytes", 128'(stat_bytes), 128'(0));
    rst = 1'b0;

    $display("[TB] immediate trigger, post 3");
    armCapture(2'd0, 4'd3, '0);
    for (int i = 1; i <= 10; i++) begin
      applyStimulus(1'b1, 1'b1, ($urandom_range(0, 3) == 0), 1'b0, '0, KW'($urandom));
      if (i == 4) checkOutput("doneAfter4", 128'(cap_state), 128'(3));
    end
    checkOutput("trigPosImm", 128'(trig_pos), 128'(0));
    readAll();

    $display("[TB] fsm trigger with ring wrap");
    armCapture(2'd2, 4'd4, 4'd5);
    for (int i = 1; i <= 40; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, (i == 30) ? 4'd5 : 4'($urandom_range(0, 4)), KW'($urandom));
    end
    checkOutput("trigPosWrap", 128'(trig_pos), 128'(11));
    readAll();

    $display("[TB] frame and byte statistics");
    clear = 1'b1;
    idle();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, '0, 8'hFF);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, '0, 8'h01);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, '0, 8'hFF);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, '0, 8'h01);
    checkOutput("framesTotal", 128'(stat_frames), 128'(3));
    checkOutput("bytesTotal", 128'(stat_bytes), 128'(18));
    checkOutput("errsTotal", 128'(stat_errs), 128'(1));

    $display("[TB] byte counter saturation");
    force dut.statBytes_q = 32'hFFFF_FFFC;
    mBytes = 64'h0000_0000_FFFF_FFFC;
    idle();
    release dut.statBytes_q;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, '0, 8'hFF);
    checkOutput("bytesSat", 128'(stat_bytes), 128'(32'hFFFF_FFFF));
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, '0, 8'hFF);
    checkOutput("bytesSatHold", 128'(stat_bytes), 128'(32'hFFFF_FFFF));

    $display("[TB] clear priority and stalled beats");
    clear = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, '0, 8'hFF);
    checkOutput("clearWins", 128'(stat_frames), 128'(0));
    armCapture(2'd3, 4'd2, '0);
    repeat (5) applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, '0, 8'hFF);
    checkOutput("stallArmed", 128'(cap_state), 128'(1));
    checkOutput("stallBytes", 128'(stat_bytes), 128'(0));
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, '0, 8'h0F);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, '0, 8'h0F);
    checkOutput("inPost", 128'(cap_state), 128'(2));

    $display("[TB] reset during post-trigger capture");
    #3;
    rst = 1'b1;
    modelReset();
    #2;
    checkOutput("rstState", 128'(cap_state), 128'(0));
    checkOutput("rstFrames", 128'(stat_frames), 128'(0));
    checkOutput("rstBytes", 128'(stat_bytes), 128'(0));
    checkOutput("rstRdData", 128'(rd_data), 128'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    armCapture(2'd3, 4'd2, '0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, '0, KW'($urandom));
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, '0, KW'($urandom));
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, '0, KW'($urandom));
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, '0, KW'($urandom));
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, '0, KW'($urandom));
    checkOutput("tlastDone", 128'(cap_state), 128'(3));
    checkOutput("tlastTrigPos", 128'(trig_pos), 128'(2));
    readAll();

    $display("[TB] randomized captures");
    for (int iter = 0; iter < 6; iter++) begin
      armCapture(2'($urandom_range(0, 3)), AW'($urandom_range(0, DEPTH - 1)), FW'($urandom));
      for (int c = 0; c < 50; c++) begin
        clear = ($urandom_range(0, 16) == 0);
        arm   = ($urandom_range(0, 24) == 0);
        applyStimulus(($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0),
                      ($urandom_range(0, 4) == 0), ($urandom_range(0, 5) == 0),
                      FW'($urandom), KW'($urandom));
      end
      readAll();
    end

    repeat (2) idle();
    checkOutput("rdQueueDrained", 128'(rdExpQ.size()), 128'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
